// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB fade sequencer and the PWM comparator stage.
// Holds the duty width, the sequencer state encoding and the duty-value type.
package rgb_pkg;
  localparam int PWM_WIDTH = 12;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_t;

  typedef logic [PWM_WIDTH-1:0] duty_t;
endpackage

// File: rtl/fade_channel.sv
// One colour channel: latched target, current duty register and clamped ramp step.
// Steps move toward the target by STEP and never pass it or wrap.
module fade_channel #(
  parameter int PWM_WIDTH = rgb_pkg::PWM_WIDTH,
  parameter int STEP      = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load,
  input  logic                 jump,
  input  logic [PWM_WIDTH-1:0] target,
  input  logic                 step_en,
  output logic [PWM_WIDTH-1:0] value,
  output logic                 at_target
);
  import rgb_pkg::*;

  localparam logic [PWM_WIDTH:0] S = (PWM_WIDTH+1)'(STEP);

  logic [PWM_WIDTH-1:0] tgt_q;
  logic [PWM_WIDTH-1:0] nxt;
  logic [PWM_WIDTH:0]   v_x;
  logic [PWM_WIDTH:0]   t_x;
  logic [PWM_WIDTH:0]   up;
  logic [PWM_WIDTH:0]   gap;

  assign at_target = (value == tgt_q);

  // one extra bit keeps the sum and the gap free of wrap
  always_comb begin
    v_x = {1'b0, value};
    t_x = {1'b0, tgt_q};
    up  = v_x + S;
    gap = v_x - t_x;
    nxt = tgt_q;
    if (t_x > v_x) begin
      if (up < t_x) nxt = up[PWM_WIDTH-1:0];
    end else if (gap > S) begin
      nxt = value - S[PWM_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tgt_q <= '0;
      value <= '0;
    end else begin
      if (load) tgt_q <= target;
      if (jump) value <= target;
      else if (step_en && !at_target) value <= nxt;
    end
  end
endmodule

// File: rtl/rgb_fade_sequencer.sv
// Command-driven linear RGB fader feeding the PWM comparator duty inputs.
// Top level: handshake, IDLE/FADE control and the step tick counter.
module rgb_fade_sequencer #(
  parameter int PWM_WIDTH  = rgb_pkg::PWM_WIDTH,
  parameter int RATE_WIDTH = 16,
  parameter int STEP       = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [PWM_WIDTH-1:0]  cmd_r,
  input  logic [PWM_WIDTH-1:0]  cmd_g,
  input  logic [PWM_WIDTH-1:0]  cmd_b,
  input  logic [RATE_WIDTH-1:0] cmd_rate,
  output logic [PWM_WIDTH-1:0]  r_val,
  output logic [PWM_WIDTH-1:0]  g_val,
  output logic [PWM_WIDTH-1:0]  b_val,
  output logic                  busy,
  output logic                  done
);
  import rgb_pkg::*;

  state_t                state;
  state_t                state_d;
  logic [RATE_WIDTH-1:0] tick;
  logic [RATE_WIDTH-1:0] tick_d;
  logic [RATE_WIDTH-1:0] rate_q;
  logic [RATE_WIDTH-1:0] rate_d;
  logic                  done_d;
  logic                  accept;
  logic                  jump;
  logic                  step_en;
  logic                  all_at;
  logic [2:0]            at;

  assign cmd_ready = (state == IDLE) && resetn;
  assign busy      = (state == FADE);
  assign accept    = cmd_valid && cmd_ready;
  assign jump      = accept && (cmd_rate == '0);
  assign all_at    = &at;
  assign step_en   = busy && !all_at && (tick == '0);

  always_comb begin
    state_d = state;
    tick_d  = tick;
    rate_d  = rate_q;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          rate_d = cmd_rate;
          tick_d = cmd_rate - RATE_WIDTH'(1);
          if (cmd_rate == '0) done_d = 1'b1;
          else state_d = FADE;
        end
      end
      FADE: begin
        if (all_at) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (tick == '0) begin
          tick_d = rate_q - RATE_WIDTH'(1);
        end else begin
          tick_d = tick - RATE_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      tick   <= '0;
      rate_q <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      tick   <= tick_d;
      rate_q <= rate_d;
      done   <= done_d;
    end
  end

  fade_channel #(.PWM_WIDTH(PWM_WIDTH), .STEP(STEP)) u_r (
    .clk(clk), .resetn(resetn), .load(accept), .jump(jump),
    .target(cmd_r), .step_en(step_en), .value(r_val), .at_target(at[0])
  );

  fade_channel #(.PWM_WIDTH(PWM_WIDTH), .STEP(STEP)) u_g (
    .clk(clk), .resetn(resetn), .load(accept), .jump(jump),
    .target(cmd_g), .step_en(step_en), .value(g_val), .at_target(at[1])
  );

  fade_channel #(.PWM_WIDTH(PWM_WIDTH), .STEP(STEP)) u_b (
    .clk(clk), .resetn(resetn), .load(accept), .jump(jump),
    .target(cmd_b), .step_en(step_en), .value(b_val), .at_target(at[2])
  );
endmodule
